// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
//   Sequencing controller that shares one 32-bit SEC corrector between host
//   reads and a background scrub engine, and writes repaired words back to
//   a word-addressed ECC memory. Host reads have priority over scrub; every
//   operation runs to completion once accepted.
//
// Optional feature macro: ECC_HOST_WB_EN
//   defined   : a host read that needed correction is also written back
//               (RSP -> WB).
//   undefined : only scrub operations repair memory (RSP -> IDLE).
//
// Ports
//   Gclk, Grst_n          clock (rising edge), async active-low reset
//   scrub_en              enables the scrub interval counter
//   host_req/host_addr    host read request (level) and address
//   host_gnt              accept pulse, combinational (IDLE && host_req)
//   host_rvalid/rdata     one-cycle corrected read response
//   mem_req/we/addr       memory command strobe, direction and address
//   mem_wdata/mem_wchk    write-back data (corrected) and check bits (as read)
//   mem_rdata/rchk/rvalid memory read return
//   cor_id/cor_ic/cor_r   corrector inputs (captured word) and enable
//   cor_od                corrector output (combinational)
//   corr_cnt              saturating count of corrected words
//   busy                  state != IDLE
//
// Handshake: host_req is a level request the host holds until it sees
// host_gnt; host_gnt is asserted only in IDLE and is the single cycle in
// which host_addr is sampled. mem_req is a one-cycle command strobe with no
// back-pressure; mem_rvalid is honoured only while waiting for a read.
module ecc_scrub_ctrl #(
    parameter int AW             = 8,
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic          Gclk,
    input  logic          Grst_n,
    input  logic          scrub_en,
    input  logic          host_req,
    input  logic [AW-1:0] host_addr,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [31:0]   host_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [7:0]    mem_wchk,
    input  logic [31:0]   mem_rdata,
    input  logic [7:0]    mem_rchk,
    input  logic          mem_rvalid,
    output logic [31:0]   cor_id,
    output logic [7:0]    cor_ic,
    output logic          cor_r,
    input  logic [31:0]   cor_od,
    output logic [15:0]   corr_cnt,
    output logic          busy
);

`ifdef ECC_HOST_WB_EN
    localparam bit HOST_WB = 1'b1;
`else
    localparam bit HOST_WB = 1'b0;
`endif

    localparam int CW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_COR  = 3'd3,
        S_RSP  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_op_host;
    logic [AW-1:0]   r_op_addr;
    logic [31:0]     r_cap_d;
    logic [7:0]      r_cap_c;
    logic [31:0]     r_fixed;
    logic            r_err;
    logic [15:0]     r_corr_cnt;
    logic [AW-1:0]   r_scrub_addr;
    logic [CW-1:0]   r_int_cnt;
    logic            r_scrub_pend;

    logic            w_acc_host;
    logic            w_acc_scrub;
    logic            w_scrub_step;
    logic            w_err;
    logic            w_int_wrap;

    // Check-bit-only errors leave the data untouched, so they never count
    // as a correction and never trigger a write-back.
    assign w_err      = (cor_od != r_cap_d);
    assign w_int_wrap = (r_int_cnt == CW'(SCRUB_INTERVAL - 1));

    always_comb begin
        w_next       = r_state;
        w_acc_host   = 1'b0;
        w_acc_scrub  = 1'b0;
        w_scrub_step = 1'b0;
        host_gnt     = 1'b0;
        host_rvalid  = 1'b0;
        host_rdata   = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wchk     = '0;
        cor_r        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (host_req) begin
                    host_gnt   = 1'b1;
                    w_acc_host = 1'b1;
                    w_next     = S_RD;
                end else if (r_scrub_pend) begin
                    w_acc_scrub = 1'b1;
                    w_next      = S_RD;
                end
            end
            S_RD: begin
                mem_req  = 1'b1;
                mem_addr = r_op_addr;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) w_next = S_COR;
            end
            S_COR: begin
                cor_r = 1'b1;
                if (r_op_host) begin
                    w_next = S_RSP;
                end else if (w_err) begin
                    w_next = S_WB;
                end else begin
                    w_next       = S_IDLE;
                    w_scrub_step = 1'b1;
                end
            end
            S_RSP: begin
                host_rvalid = 1'b1;
                host_rdata  = r_fixed;
                w_next      = (r_err && HOST_WB) ? S_WB : S_IDLE;
            end
            S_WB: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = r_op_addr;
                mem_wdata    = r_fixed;
                mem_wchk     = r_cap_c;
                w_next       = S_IDLE;
                w_scrub_step = !r_op_host;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Gclk or negedge Grst_n) begin
        if (!Grst_n) begin
            r_state      <= S_IDLE;
            r_op_host    <= 1'b0;
            r_op_addr    <= '0;
            r_cap_d      <= '0;
            r_cap_c      <= '0;
            r_fixed      <= '0;
            r_err        <= 1'b0;
            r_corr_cnt   <= '0;
            r_scrub_addr <= '0;
            r_int_cnt    <= '0;
            r_scrub_pend <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_acc_host) begin
                r_op_host <= 1'b1;
                r_op_addr <= host_addr;
            end else if (w_acc_scrub) begin
                r_op_host <= 1'b0;
                r_op_addr <= r_scrub_addr;
            end

            if (r_state == S_WAIT && mem_rvalid) begin
                r_cap_d <= mem_rdata;
                r_cap_c <= mem_rchk;
            end

            if (r_state == S_COR) begin
                r_fixed <= cor_od;
                r_err   <= w_err;
                if (w_err && r_corr_cnt != 16'hFFFF) r_corr_cnt <= r_corr_cnt + 16'd1;
            end

            if (w_scrub_step) r_scrub_addr <= r_scrub_addr + 1'b1;

            // A new interval expiry wins over consuming the pending request,
            // so pend never drops a tick; requests still do not accumulate.
            if (!scrub_en) begin
                r_int_cnt    <= '0;
                r_scrub_pend <= 1'b0;
            end else if (w_int_wrap) begin
                r_int_cnt    <= '0;
                r_scrub_pend <= 1'b1;
            end else begin
                r_int_cnt <= r_int_cnt + 1'b1;
                if (w_acc_scrub) r_scrub_pend <= 1'b0;
            end
        end
    end

    assign cor_id   = r_cap_d;
    assign cor_ic   = r_cap_c;
    assign corr_cnt = r_corr_cnt;
    assign busy     = (r_state != S_IDLE);

endmodule
